useq_ctrl: RTL

//  Microsequencer controller; owns the micro-program counter (upc) and picks the next microword address each cycle.

---
 rtl/useq_pkg.sv | 26 ++
 rtl/useq_stack.sv | 58 +++++
 rtl/useq_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/useq_pkg.sv
// Shared types and default sizes for the microsequencer.
package useq_pkg;

    localparam int AW_DEFAULT    = 5;
    localparam int NCOND_DEFAULT = 4;
    localparam int DEPTH_DEFAULT = 4;

    // Branch field of a microword; encodings match the microcode format.
    typedef enum logic [2:0] {
        NEXT = 3'd0,
        JMP  = 3'd1,
        BRT  = 3'd2,
        BRF  = 3'd3,
        CALL = 3'd4,
        RET  = 3'd5,
        WAIT = 3'd6,
        END  = 3'd7
    } br_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/useq_stack.sv
// Return-address LIFO for CALL/RET. Push is ignored when full and pop when
// empty; the controller decides what those cases mean for sequencing.
module useq_stack
    import useq_pkg::*;
#(
    parameter int AW    = AW_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_data,
    output logic [AW-1:0] top_data,
    output logic          full,
    output logic          empty
);
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SPW-1:0] sp_q, sp_d;
    logic [AW-1:0]  mem_q [DEPTH];
    logic [AW-1:0]  mem_d [DEPTH];
    logic [IW-1:0]  wr_idx, rd_idx;

    assign full     = (sp_q == SPW'(DEPTH));
    assign empty    = (sp_q == '0);
    assign wr_idx   = IW'(sp_q);
    assign rd_idx   = IW'(sp_q - 1'b1);
    assign top_data = mem_q[rd_idx];

    // Pointer and storage update; clear wins over push/pop.
    always_comb begin
        sp_d  = sp_q;
        mem_d = mem_q;
        if (clr) begin
            sp_d = '0;
        end else if (push && !full) begin
            mem_d[wr_idx] = push_data;
            sp_d          = sp_q + 1'b1;
        end else if (pop && !empty) begin
            sp_d = sp_q - 1'b1;
        end
    end

    // Stack registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            sp_q  <= sp_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/useq_ctrl.sv
// Microsequencer controller: owns the micro-program counter and selects the
// next microword address each cycle from the current microword's branch field.
// Build option: define UPC_STACK_EN to add the CALL/RET return-address stack
// and the sticky err flag; without it CALL acts as JMP, RET as NEXT, err = 0.
//
// state | meaning
// IDLE  | upc held at 0, waiting for start
// RUN   | executing one microword per cycle
// DONE  | one-cycle done pulse, upc returns to 0
module useq_ctrl
    import useq_pkg::*;
#(
    parameter int AW    = AW_DEFAULT,
    parameter int NCOND = NCOND_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NCOND-1:0] cond,
    input  logic [2:0]       br_type,
    input  logic [1:0]       br_sel,
    input  logic [AW-1:0]    br_addr,
    output logic [AW-1:0]    upc,
    output logic             busy,
    output logic             done,
    output logic             err
);
    // Pad the flags to at least four bits so any br_sel value indexes a
    // defined bit; selects beyond NCOND read as 0.
    localparam int CW = (NCOND > 4) ? NCOND : 4;

    state_e        state_q, state_d;
    br_type_e      br_op;
    logic [AW-1:0] upc_q, upc_d, upc_inc;
    logic [CW-1:0] cond_ext;
    logic          c;
    logic          start_go;

    assign cond_ext = CW'(cond);
    assign c        = cond_ext[br_sel];
    assign upc_inc  = upc_q + 1'b1;
    assign br_op    = br_type_e'(br_type);
    assign start_go = (state_q == IDLE) && start;
    assign upc      = upc_q;

`ifdef UPC_STACK_EN
    logic          err_q, err_d;
    logic          stk_push, stk_pop, stk_full, stk_empty;
    logic [AW-1:0] stk_top;

    useq_stack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .clr       (start_go),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (upc_inc),
        .top_data  (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // Sticky stack error flag.
    always_ff @(posedge clk) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign err = err_q;
`else
    logic unused_depth;
    assign unused_depth = (DEPTH > 0);
    assign err          = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (br_op == END) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Next-address mux plus stack control; END holds upc until DONE clears it.
    always_comb begin
        upc_d = upc_q;
`ifdef UPC_STACK_EN
        err_d    = err_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        if (start_go) err_d = 1'b0;
`endif
        case (state_q)
            RUN: begin
                case (br_op)
                    NEXT: upc_d = upc_inc;
                    JMP:  upc_d = br_addr;
                    BRT:  upc_d = c ? br_addr : upc_inc;
                    BRF:  upc_d = c ? upc_inc : br_addr;
`ifdef UPC_STACK_EN
                    CALL: begin
                        if (stk_full) begin
                            upc_d = upc_inc;
                            err_d = 1'b1;
                        end else begin
                            stk_push = 1'b1;
                            upc_d    = br_addr;
                        end
                    end
                    RET: begin
                        if (stk_empty) begin
                            upc_d = upc_inc;
                            err_d = 1'b1;
                        end else begin
                            stk_pop = 1'b1;
                            upc_d   = stk_top;
                        end
                    end
`else
                    CALL: upc_d = br_addr;
                    RET:  upc_d = upc_inc;
`endif
                    WAIT:    upc_d = c ? upc_inc : upc_q;
                    END:     upc_d = upc_q;
                    default: upc_d = upc_inc;
                endcase
            end
            default: upc_d = '0;
        endcase
    end

    // Micro-program counter.
    always_ff @(posedge clk) begin
        if (reset) upc_q <= '0;
        else       upc_q <= upc_d;
    end

endmodule
